wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Single-outstanding Wishbone B4 pipelined bus master. Sits directly upstream of the peripheral slaves, such as the LED/register slave on the 2-bit address map.
- Accepts one command (read/write, address, data) on a valid/ready port and drives one bus cycle, honouring stall.
- Waits for ack or err, bounded by a timeout.
- Returns a response (data plus status) on a second valid/ready port.

Parameters:
- ADDR_W, 2, Wishbone address width; matches the slave address map.
- DATA_W, 32, Wishbone data width.
- TIMEOUT_CYCLES, 255, maximum number of cycles from bus issue to ack/err before the master aborts; legal range 1..2^TMO_W-1.
- TMO_W, 8, width of the timeout counter.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted this cycle when valid&ready
- i_cmd_we  in  1  1=write, 0=read
- i_cmd_addr  in  ADDR_W  target address
- i_cmd_data  in  DATA_W  write data
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_data  out  DATA_W  read data; 0 for writes and failed transactions
- o_rsp_status  out  2  00=OK, 01=bus error, 10=timeout, 11=reserved
- o_busy  out  1  high whenever state != IDLE
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  strobe
- o_wb_we  out  1  write enable
- o_wb_addr  out  ADDR_W  address
- o_wb_odata  out  DATA_W  write data to slave
- i_wb_ack  in  1  slave acknowledge
- i_wb_stall  in  1  slave stall
- i_wb_err  in  1  slave error
- i_wb_idata  in  DATA_W  read data from slave

Behaviour:
- Reset is asynchronous and active-low. While i_reset_n=0:
  - state=IDLE.
  - All outputs are 0 except o_cmd_ready, which is combinational and therefore 1 in IDLE.
  - Timeout counter = 0.
- Reset mid-transaction drops o_wb_cyc/o_wb_stb immediately (asynchronously). No response is generated for the aborted command.
- All bus outputs and rsp outputs are registered. o_cmd_ready = (state==IDLE). o_busy = (state!=IDLE).
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On i_cmd_valid: latch we/addr/data into the bus outputs, set cyc=stb=1, clear the timeout counter, go to REQ.
- REQ (cyc=1, stb=1):
  - stb is accepted in any cycle where i_wb_stall=0.
  - Accepted with i_wb_err=1: drop cyc/stb, status=01, data=0, go to RESP.
  - Accepted with i_wb_ack=1 (and no err): drop cyc/stb, status=00, capture data (i_wb_idata if read, 0 if write), go to RESP. This covers zero-wait slaves that ack in the same cycle as stb.
  - Accepted with neither: drop stb, keep cyc, go to WAIT.
  - Stalled: hold all bus outputs stable.
- WAIT (cyc=1, stb=0):
  - i_wb_err → status 01.
  - i_wb_ack (no err) → status 00 with data captured as in REQ.
  - Either case: drop cyc, go to RESP.
- Timeout, in REQ or WAIT:
  - The counter increments every cycle; the event is evaluated after the ack/err checks.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack/err that cycle: drop cyc/stb, status=10, data=0, go to RESP.
- Priority when events coincide: err > ack > timeout.
- RESP:
  - o_rsp_valid=1; data and status are held stable until i_rsp_ready.
  - On i_rsp_ready: rsp_valid←0, go to IDLE. A new command is accepted no earlier than the following cycle.
- Ack/err arriving in IDLE or RESP is ignored and causes no state change.
- Latency with a zero-wait slave:
  - command accepted at cycle 0;
  - stb high at cycle 1;
  - ack at cycle 1;
  - o_rsp_valid at cycle 2.
- Throughput: one transaction per 3 cycles minimum.
- o_wb_we/o_wb_addr/o_wb_odata hold their values from stb rise until cyc falls. Their values are don't-care when cyc=0.

Decomposition:
- Shared package (wb_pkg):
  - FSM state encoding (2-bit);
  - status codes RSP_OK=2'b00, RSP_BUSERR=2'b01, RSP_TIMEOUT=2'b10;
  - default ADDR_W/DATA_W.
- Single flat module. The timeout counter is small enough to stay inline; no sub-module.

Test Plan:
- Write, zero-wait slave: cmd we=1 addr=1 data=0x00000001 → stb asserted 1 cycle after accept, ack same cycle, rsp_valid next cycle with status=00, data=0; slave LED driven low.
- Read with stall: i_wb_stall high for 3 cycles, ack 2 cycles after stall drops, i_wb_idata=0xDEADBEEF → stb/addr stable during stall, rsp status=00, data=0xDEADBEEF.
- Timeout: TIMEOUT_CYCLES=4, slave never acks → cyc drops after 4 bus cycles, rsp status=10, data=0.
- Error with coincident ack: i_wb_err=1 and i_wb_ack=1 on the same cycle → status=01, data=0.
- Backpressure: i_rsp_ready low for 5 cycles while a second cmd is valid → rsp held stable, o_cmd_ready=0, no new stb until after handshake.
- Reset mid-WAIT: drop i_reset_n → cyc/stb/rsp_valid go 0 asynchronously; after release, the next cmd completes normally with status=00.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command master: FSM encoding,
// response status codes and default bus widths.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_BUSERR  = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;

    localparam int WB_ADDR_W = 2;
    localparam int WB_DATA_W = 32;

endpackage

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 pipelined master: one command in, one bus
// cycle out (stall-aware, timeout-bounded), one response back.
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int ADDR_W         = WB_ADDR_W,
    parameter int DATA_W         = WB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [1:0]        o_rsp_status,
    output logic              o_busy,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_odata,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    input  logic              i_wb_err,
    input  logic [DATA_W-1:0] i_wb_idata
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic              accepted;
    logic              finish;
    logic [1:0]        fin_status;
    logic [DATA_W-1:0] fin_data;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        addr_d       = addr_q;
        odata_d      = odata_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        tmo_d        = tmo_q;
        accepted     = 1'b0;
        finish       = 1'b0;
        fin_status   = RSP_OK;
        fin_data     = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    we_d    = i_cmd_we;
                    addr_d  = i_cmd_addr;
                    odata_d = i_cmd_data;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_WAIT: begin
                // In WAIT the strobe has already been taken, so ack/err count at once.
                accepted = (state_q == ST_WAIT) || !i_wb_stall;
                tmo_d    = tmo_q + 1'b1;
                if (accepted && i_wb_err) begin
                    finish     = 1'b1;
                    fin_status = RSP_BUSERR;
                end else if (accepted && i_wb_ack) begin
                    finish     = 1'b1;
                    fin_status = RSP_OK;
                    fin_data   = we_q ? '0 : i_wb_idata;
                end else if (tmo_q == TMO_LAST) begin
                    finish     = 1'b1;
                    fin_status = RSP_TIMEOUT;
                end else if (state_q == ST_REQ && accepted) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    rsp_data_d   = '0;
                    rsp_status_d = RSP_OK;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            cyc_d        = 1'b0;
            stb_d        = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_data_d   = fin_data;
            rsp_status_d = fin_status;
            state_d      = ST_RESP;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            odata_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= RSP_OK;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            odata_q      <= odata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            tmo_q        <= tmo_d;
        end
    end

    assign o_cmd_ready  = (state_q == ST_IDLE);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_status = rsp_status_q;
    assign o_wb_cyc     = cyc_q;
    assign o_wb_stb     = stb_q;
    assign o_wb_we      = we_q;
    assign o_wb_addr    = addr_q;
    assign o_wb_odata   = odata_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: two instances (long and short timeout) driven by
// transaction-level tasks and checked against a per-transaction outcome model.
module tb_wb_cmd_master;
    import wb_pkg::*;

    localparam int TMO_A = 255;
    localparam int TMO_B = 4;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        cmd_valid, cmd_we, rsp_ready;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        wb_ack, wb_stall, wb_err;
    logic [31:0] wb_idata;

    logic        a_cmd_ready, a_rsp_valid, a_busy, a_cyc, a_stb, a_we;
    logic [31:0] a_rsp_data, a_odata;
    logic [1:0]  a_rsp_status, a_addr;
    logic        b_cmd_ready, b_rsp_valid, b_busy, b_cyc, b_stb, b_we;
    logic [31:0] b_rsp_data, b_odata;
    logic [1:0]  b_rsp_status, b_addr;

    logic        cmd_ready, rsp_valid, busy, cyc, stb, we;
    logic [31:0] rsp_data, odata;
    logic [1:0]  rsp_status, addr;

    int n_checks = 0;
    int n_errors = 0;

    wb_cmd_master #(.ADDR_W(2), .DATA_W(32), .TIMEOUT_CYCLES(TMO_A), .TMO_W(8)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid & ~sel), .o_cmd_ready(a_cmd_ready),
        .i_cmd_we(cmd_we), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready & ~sel),
        .o_rsp_data(a_rsp_data), .o_rsp_status(a_rsp_status), .o_busy(a_busy),
        .o_wb_cyc(a_cyc), .o_wb_stb(a_stb), .o_wb_we(a_we), .o_wb_addr(a_addr),
        .o_wb_odata(a_odata), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall),
        .i_wb_err(wb_err), .i_wb_idata(wb_idata)
    );

    wb_cmd_master #(.ADDR_W(2), .DATA_W(32), .TIMEOUT_CYCLES(TMO_B), .TMO_W(8)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid & sel), .o_cmd_ready(b_cmd_ready),
        .i_cmd_we(cmd_we), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready & sel),
        .o_rsp_data(b_rsp_data), .o_rsp_status(b_rsp_status), .o_busy(b_busy),
        .o_wb_cyc(b_cyc), .o_wb_stb(b_stb), .o_wb_we(b_we), .o_wb_addr(b_addr),
        .o_wb_odata(b_odata), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall),
        .i_wb_err(wb_err), .i_wb_idata(wb_idata)
    );

    assign cmd_ready  = sel ? b_cmd_ready  : a_cmd_ready;
    assign rsp_valid  = sel ? b_rsp_valid  : a_rsp_valid;
    assign rsp_data   = sel ? b_rsp_data   : a_rsp_data;
    assign rsp_status = sel ? b_rsp_status : a_rsp_status;
    assign busy       = sel ? b_busy       : a_busy;
    assign cyc        = sel ? b_cyc        : a_cyc;
    assign stb        = sel ? b_stb        : a_stb;
    assign we         = sel ? b_we         : a_we;
    assign addr       = sel ? b_addr       : a_addr;
    assign odata      = sel ? b_odata      : a_odata;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_ready);
        check({tag, "_cyc"}, {31'd0, cyc}, 32'd0);
        check({tag, "_stb"}, {31'd0, stb}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, ~exp_ready});
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, {31'd0, exp_ready});
    endtask

    // kind: 0 ack, 1 err, 2 err+ack together, 3 slave silent.
    // The slave stalls for stall_n bus cycles, then answers dly cycles after
    // the strobe is taken. Enter and leave just after a rising edge.
    task automatic run_txn(input logic t_we, input logic [1:0] t_addr, input logic [31:0] t_wdata,
                           input int stall_n, input int dly, input int kind,
                           input logic [31:0] rdata, input int tmo);
        int          r, end_c, cyc_n, hold;
        logic [1:0]  exp_st;
        logic [31:0] exp_d, held_d;
        logic [1:0]  held_st;

        r = stall_n + dly;
        if (kind != 3 && r <= tmo - 1) begin
            end_c  = r;
            exp_st = (kind == 0) ? RSP_OK : RSP_BUSERR;
        end else begin
            end_c  = tmo - 1;
            exp_st = RSP_TIMEOUT;
        end
        exp_d = (exp_st == RSP_OK && !t_we) ? rdata : 32'd0;

        cmd_valid = 1'b1; cmd_we = t_we; cmd_addr = t_addr; cmd_data = t_wdata;
        wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
        @(negedge clk);
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;

        cyc_n = 0;
        for (int k = 0; k < 300; k++) begin
            // a competing command must not disturb the cycle in flight
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_addr  = 2'($urandom_range(0, 3));
            cmd_data  = $urandom;
            wb_stall  = (k < stall_n);
            wb_ack    = (kind == 0 || kind == 2) && (k == r);
            wb_err    = (kind == 1 || kind == 2) && (k == r);
            wb_idata  = (k == r) ? rdata : $urandom;
            @(negedge clk);
            if (!cyc) break;
            cyc_n++;
            check("stb", {31'd0, stb}, {31'd0, 1'(k <= stall_n)});
            check("wb_we", {31'd0, we}, {31'd0, t_we});
            check("wb_addr", {30'd0, addr}, {30'd0, t_addr});
            check("wb_odata", odata, t_wdata);
            check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("bus_cycles", cyc_n, end_c + 1);

        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_status", {30'd0, rsp_status}, {30'd0, exp_st});
        check("rsp_data", rsp_data, exp_d);
        check("stb_resp", {31'd0, stb}, 32'd0);
        held_d = rsp_data; held_st = rsp_status;

        hold = $urandom_range(0, 5);
        for (int j = 0; j < hold; j++) begin
            rsp_ready = 1'b0; cmd_valid = 1'b1;
            wb_ack = 1'($urandom_range(0, 1)); wb_err = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_data", rsp_data, held_d);
            check("hold_status", {30'd0, rsp_status}, {30'd0, held_st});
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("hold_cyc", {31'd0, cyc}, 32'd0);
        end

        rsp_ready = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_rsp", 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 2'd0; cmd_data = 32'd0;
        rsp_ready = 1'b0; wb_ack = 1'b0; wb_stall = 1'b0; wb_err = 1'b0; wb_idata = 32'd0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_a", 1'b1);
        check("reset_rsp_data", rsp_data, 32'd0);
        sel = 1'b1; #1;
        check_idle_outputs("reset_b", 1'b1);
        sel = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed cases
        run_txn(1'b1, 2'd1, 32'h0000_0001, 0, 0, 0, 32'hFFFF_FFFF, TMO_A);
        run_txn(1'b0, 2'd2, 32'h1234_5678, 3, 2, 0, 32'hDEAD_BEEF, TMO_A);
        run_txn(1'b0, 2'd3, 32'h0, 0, 1, 2, 32'hCAFE_F00D, TMO_A);
        sel = 1'b1;
        run_txn(1'b0, 2'd0, 32'h0, 0, 0, 3, 32'h0BAD_0BAD, TMO_B);
        run_txn(1'b0, 2'd1, 32'h0, 1, 2, 0, 32'h5555_AAAA, TMO_B);
        run_txn(1'b1, 2'd2, 32'h7, 5, 0, 0, 32'h1111_2222, TMO_B);
        sel = 1'b0;

        // ack/err with no cycle open must be ignored
        wb_ack = 1'b1; wb_err = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("stray_ack", 1'b1);
        wb_ack = 1'b0; wb_err = 1'b0;
        @(posedge clk); #1;

        // randomized transactions against both timeouts
        for (int n = 0; n < 40; n++) begin
            int kind_sel;
            sel = (n >= 28);
            kind_sel = $urandom_range(0, 9);
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    (kind_sel == 9) ? 3 : kind_sel % 3, $urandom,
                    sel ? TMO_B : TMO_A);
        end
        sel = 1'b0;

        // asynchronous reset while waiting for the slave
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd1; cmd_data = 32'd0;
        wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("pre_reset_cyc", {31'd0, cyc}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset", 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 2'd3, 32'h0, 0, 1, 0, 32'hA5A5_5A5A, TMO_A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
